// File: rtl/sd_data_pkg.sv
// Shared constants for the SD data-block controller: state encoding and default widths.
package sd_data_pkg;

    localparam int BLOCKS_W_DEF  = 8;
    localparam int TIMEOUT_W_DEF = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CHECK = 3'd1;
    localparam state_t ST_SEND  = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_ACK   = 3'd4;
    localparam state_t ST_DONE  = 3'd5;
    localparam state_t ST_TOUT  = 3'd6;

endpackage

// File: rtl/sd_data_block_ctrl_if.sv
// Host/physical-layer handshake bundle for the data-block controller.
interface sd_data_block_ctrl_if
    import sd_data_pkg::*;
#(
    parameter int BLOCKS_W  = BLOCKS_W_DEF,
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
);

    logic                 iNewData;
    logic                 iWriteRead;
    logic                 iMultipleData;
    logic [BLOCKS_W-1:0]  iBlocks;
    logic                 iTimeout_enable;
    logic [TIMEOUT_W-1:0] iTimeout_reg;
    logic                 iTimeout;
    logic                 iSerial_ready;
    logic                 iFIFO_ok;
    logic                 iComplete;
    logic                 iAck;
    logic                 iAbort;

    logic                 oSend;
    logic                 oAck;
    logic                 oIdle;
    logic                 oWriteRead;
    logic                 oMultipleData;
    logic                 oData_transfer_complete;
    logic                 oTimeout_err;
    logic [BLOCKS_W-1:0]  oBlocks_done;

    modport slave (
        input  iNewData, iWriteRead, iMultipleData, iBlocks, iTimeout_enable,
               iTimeout_reg, iTimeout, iSerial_ready, iFIFO_ok, iComplete, iAck, iAbort,
        output oSend, oAck, oIdle, oWriteRead, oMultipleData,
               oData_transfer_complete, oTimeout_err, oBlocks_done
    );

    modport master (
        output iNewData, iWriteRead, iMultipleData, iBlocks, iTimeout_enable,
               iTimeout_reg, iTimeout, iSerial_ready, iFIFO_ok, iComplete, iAck, iAbort,
        input  oSend, oAck, oIdle, oWriteRead, oMultipleData,
               oData_transfer_complete, oTimeout_err, oBlocks_done
    );

endinterface

// File: rtl/sd_timeout_counter.sv
// Per-block down-counter: reloads on load, counts toward zero while enabled, flags zero.
module sd_timeout_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] reload,
    output logic         expired
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Holds at zero rather than wrapping so expiry stays asserted.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = reload;
        end else if (enable && (count_reg != '0)) begin
            count_next = count_reg - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/sd_data_block_ctrl.sv
// SD host data-control FSM: sequences single/multi-block transfers with timeout, abort and block count.
module sd_data_block_ctrl
    import sd_data_pkg::*;
#(
    parameter int BLOCKS_W  = BLOCKS_W_DEF,
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input logic                 iClock,
    input logic                 iReset,
    sd_data_block_ctrl_if.slave bus
);

    state_t              state_reg;
    state_t              state_next;
    logic [BLOCKS_W-1:0] remaining_reg;
    logic [BLOCKS_W-1:0] remaining_next;
    logic [BLOCKS_W-1:0] blocks_done_reg;
    logic [BLOCKS_W-1:0] blocks_done_next;
    logic                dir_reg;
    logic                dir_next;
    logic                mode_reg;
    logic                mode_next;
    logic                err_reg;
    logic                err_next;
    logic [BLOCKS_W-1:0] start_count;
    logic                tmr_load;
    logic                tmr_enable;
    logic                tmr_expired;

    assign start_count = bus.iMultipleData ? bus.iBlocks : BLOCKS_W'(1);
    assign tmr_load    = (state_reg == ST_SEND);
    assign tmr_enable  = (state_reg == ST_WAIT) && bus.iTimeout_enable;

    sd_timeout_counter #(
        .W(TIMEOUT_W)
    ) u_timeout (
        .clk     (iClock),
        .rst_n   (iReset),
        .load    (tmr_load),
        .enable  (tmr_enable),
        .reload  (bus.iTimeout_reg),
        .expired (tmr_expired)
    );

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Abort takes priority over every handshake outside IDLE.
    always_comb begin
        state_next = state_reg;
        if ((state_reg != ST_IDLE) && bus.iAbort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.iNewData) begin
                        state_next = (start_count == '0) ? ST_DONE : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bus.iFIFO_ok && bus.iSerial_ready) begin
                        state_next = ST_SEND;
                    end
                end
                ST_SEND: state_next = ST_WAIT;
                ST_WAIT: begin
                    if (bus.iComplete) begin
                        state_next = ST_ACK;
                    end else if (bus.iTimeout || (bus.iTimeout_enable && tmr_expired)) begin
                        state_next = ST_TOUT;
                    end
                end
                ST_ACK: begin
                    if (bus.iAck) begin
                        state_next = (remaining_reg <= BLOCKS_W'(1)) ? ST_DONE : ST_CHECK;
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                ST_TOUT: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        remaining_next   = remaining_reg;
        blocks_done_next = blocks_done_reg;
        dir_next         = dir_reg;
        mode_next        = mode_reg;
        err_next         = err_reg;
        if ((state_reg == ST_IDLE) && bus.iNewData) begin
            dir_next         = bus.iWriteRead;
            mode_next        = bus.iMultipleData;
            remaining_next   = start_count;
            blocks_done_next = '0;
            err_next         = 1'b0;
        end
        if ((state_reg == ST_ACK) && bus.iAck && !bus.iAbort) begin
            if (blocks_done_reg != '1) begin
                blocks_done_next = blocks_done_reg + BLOCKS_W'(1);
            end
            if (remaining_reg != '0) begin
                remaining_next = remaining_reg - BLOCKS_W'(1);
            end
        end
        // Set on entry so the flag is visible in the same cycle as TOUT.
        if (state_next == ST_TOUT) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            remaining_reg   <= '0;
            blocks_done_reg <= '0;
            dir_reg         <= 1'b0;
            mode_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            remaining_reg   <= remaining_next;
            blocks_done_reg <= blocks_done_next;
            dir_reg         <= dir_next;
            mode_reg        <= mode_next;
            err_reg         <= err_next;
        end
    end

    always_comb begin
        bus.oSend                   = (state_reg == ST_SEND) && !bus.iAbort;
        bus.oAck                    = (state_reg == ST_ACK) && !bus.iAbort;
        bus.oData_transfer_complete = (state_reg == ST_DONE) && !bus.iAbort;
        bus.oIdle                   = (state_reg == ST_IDLE);
        bus.oWriteRead              = dir_reg;
        bus.oMultipleData           = mode_reg;
        bus.oTimeout_err            = err_reg;
        bus.oBlocks_done            = blocks_done_reg;
    end

endmodule

// File: tb/tb_sd_data_block_ctrl.sv
// Self-checking bench: reactive physical-layer stub, table vectors, random transfers vs a transaction model.
module tb_sd_data_block_ctrl;

    localparam int BW     = 8;
    localparam int TW     = 16;
    localparam int BUDGET = 3000;

    typedef struct {
        bit dir;
        bit multi;
        int blocks;
        bit tmo_en;
        int treg;
        int fifo;       // FIFO-stall cycles at start of every block
        int cpl_d;      // WAIT cycle index at which the phy responds; <0 never
        int ack_d;      // cycles of oAck before iAck
        int abort_blk;  // abort in first WAIT cycle of this block; 0 none
        bit ext;        // phy answers with iTimeout instead of iComplete
        int rst_blk;    // stop with oAck high on this block (reset test)
    } xfer_t;

    typedef struct {
        int sends;
        int acks;
        int done;
        int cpl;
        int err;
        int err_cyc;
        int first_send;
        int dir;
        int multi;
        int latch_bad;
        int hit;
    } res_t;

    typedef struct {
        xfer_t x;
        int    e_sends;
        int    e_acks;
        int    e_done;
        int    e_cpl;
        int    e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    sd_data_block_ctrl_if #(.BLOCKS_W(BW), .TIMEOUT_W(TW)) bus ();

    sd_data_block_ctrl #(.BLOCKS_W(BW), .TIMEOUT_W(TW)) dut (
        .iClock (clk),
        .iReset (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t res_init();
        res_t r;
        r.sends = 0; r.acks = 0; r.done = 0; r.cpl = 0; r.err = 0;
        r.err_cyc = -1; r.first_send = -1; r.dir = 0; r.multi = 0;
        r.latch_bad = 0; r.hit = 0;
        return r;
    endfunction

    function automatic xfer_t mk(input bit dir, input bit multi, input int blocks, input bit en,
                                 input int treg, input int fifo, input int d, input int a,
                                 input int ab, input bit ext);
        xfer_t x;
        x.dir = dir; x.multi = multi; x.blocks = blocks; x.tmo_en = en; x.treg = treg;
        x.fifo = fifo; x.cpl_d = d; x.ack_d = a; x.abort_blk = ab; x.ext = ext; x.rst_blk = 0;
        return x;
    endfunction

    function automatic vec_t vec(input xfer_t x, input int s, input int ac, input int dn,
                                 input int c, input int e);
        vec_t v;
        v.x = x; v.e_sends = s; v.e_acks = ac; v.e_done = dn; v.e_cpl = c; v.e_err = e;
        return v;
    endfunction

    // Transaction-level expectation: per block, the phy answer either lands inside the timeout
    // window (WAIT index <= reload+1; completion wins a tie) or the block ends in a timeout.
    function automatic res_t model(input xfer_t x);
        res_t e;
        int   n;
        int   k_tmo;
        bit   ok;
        e = res_init();
        e.dir = x.dir;
        e.multi = x.multi;
        n = x.multi ? x.blocks : 1;
        if (n > 0 && x.fifo == 0) e.first_send = 2;
        k_tmo = 1 << 30;
        if (x.tmo_en) k_tmo = x.treg + 1;
        if (x.ext && x.cpl_d > 0 && x.cpl_d < k_tmo) k_tmo = x.cpl_d;
        ok = !x.ext && x.cpl_d > 0 && x.cpl_d <= k_tmo;
        for (int b = 1; b <= n; b++) begin
            e.sends++;
            if (x.abort_blk == b) return e;
            if (!ok) begin
                e.err = 1;
                e.err_cyc = k_tmo + 1;
                return e;
            end
            e.acks++;
            e.done++;
        end
        e.cpl = 1;
        return e;
    endfunction

    task automatic idle_inputs();
        bus.iNewData = 0; bus.iWriteRead = 0; bus.iMultipleData = 0; bus.iBlocks = '0;
        bus.iTimeout_enable = 0; bus.iTimeout_reg = '0; bus.iTimeout = 0;
        bus.iSerial_ready = 1; bus.iFIFO_ok = 0; bus.iComplete = 0; bus.iAck = 0;
        bus.iAbort = 0;
    endtask

    task automatic run_xfer(input xfer_t x, output res_t r);
        int fifo_cnt, cpl_cnt, ack_cnt, last_send;
        bit abort_arm;
        r = res_init();
        @(negedge clk);
        bus.iNewData = 1; bus.iWriteRead = x.dir; bus.iMultipleData = x.multi;
        bus.iBlocks = BW'(x.blocks); bus.iTimeout_enable = x.tmo_en;
        bus.iTimeout_reg = TW'(x.treg);
        fifo_cnt = x.fifo;
        bus.iFIFO_ok = (fifo_cnt == 0);
        cpl_cnt = 0; ack_cnt = -1; last_send = 0; abort_arm = 0;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge clk);
            if (bus.oIdle) break;
            if (x.rst_blk != 0 && bus.oAck && r.sends == x.rst_blk) begin
                r.hit = 1;
                return;
            end
            if (bus.oWriteRead !== x.dir || bus.oMultipleData !== x.multi) r.latch_bad = 1;
            if (bus.oTimeout_err && r.err_cyc < 0) r.err_cyc = cyc - last_send;
            r.cpl += int'(bus.oData_transfer_complete);
            // Start requests while busy must be ignored; offer conflicting ones.
            bus.iNewData = ($urandom_range(3) == 0);
            bus.iWriteRead = ~x.dir; bus.iMultipleData = ~x.multi; bus.iBlocks = BW'($urandom);
            bus.iComplete = 0; bus.iTimeout = 0; bus.iAck = 0; bus.iAbort = 0;
            if (fifo_cnt > 0) fifo_cnt--;
            bus.iFIFO_ok = (fifo_cnt == 0);
            if (bus.oSend) begin
                r.sends++;
                if (r.first_send < 0) r.first_send = cyc;
                last_send = cyc;
                cpl_cnt = x.cpl_d;
                if (r.sends == x.abort_blk) abort_arm = 1;
            end else begin
                if (cpl_cnt > 0) begin
                    cpl_cnt--;
                    if (cpl_cnt == 0) begin
                        if (x.ext) bus.iTimeout = 1;
                        else bus.iComplete = 1;
                    end
                end
                if (abort_arm) begin
                    bus.iAbort = 1;
                    abort_arm = 0;
                end
            end
            if (bus.oAck) begin
                if (ack_cnt < 0) ack_cnt = x.ack_d;
                if (ack_cnt == 0) begin
                    bus.iAck = 1;
                    r.acks++;
                    ack_cnt = -1;
                    fifo_cnt = x.fifo;
                    bus.iFIFO_ok = (fifo_cnt == 0);
                end else begin
                    ack_cnt--;
                end
            end
        end
        chk("return to idle within budget", int'(bus.oIdle), 1);
        r.done  = int'(bus.oBlocks_done);
        r.err   = int'(bus.oTimeout_err);
        r.dir   = int'(bus.oWriteRead);
        r.multi = int'(bus.oMultipleData);
        idle_inputs();
    endtask

    task automatic check_res(input string tag, input res_t r, input res_t e);
        chk({tag, " oSend count"}, r.sends, e.sends);
        chk({tag, " ack handshakes"}, r.acks, e.acks);
        chk({tag, " oBlocks_done"}, r.done, e.done);
        chk({tag, " complete pulses"}, r.cpl, e.cpl);
        chk({tag, " oTimeout_err"}, r.err, e.err);
        chk({tag, " err cycles after send"}, r.err_cyc, e.err_cyc);
        chk({tag, " oWriteRead"}, r.dir, e.dir);
        chk({tag, " oMultipleData"}, r.multi, e.multi);
        chk({tag, " latch stable while busy"}, r.latch_bad, 0);
        if (e.first_send >= 0) chk({tag, " start to oSend"}, r.first_send, e.first_send);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " oIdle"}, int'(bus.oIdle), 1);
        chk({tag, " oSend"}, int'(bus.oSend), 0);
        chk({tag, " oAck"}, int'(bus.oAck), 0);
        chk({tag, " oBlocks_done"}, int'(bus.oBlocks_done), 0);
        chk({tag, " oTimeout_err"}, int'(bus.oTimeout_err), 0);
        chk({tag, " oWriteRead"}, int'(bus.oWriteRead), 0);
        chk({tag, " oMultipleData"}, int'(bus.oMultipleData), 0);
        chk({tag, " complete"}, int'(bus.oData_transfer_complete), 0);
    endtask

    vec_t  tbl[12];
    xfer_t xr;
    res_t  r, e;

    initial begin
        tbl[0]  = vec(mk(1, 0, 5, 1, 100, 0, 3, 1, 0, 0), 1, 1, 1, 1, 0);
        tbl[1]  = vec(mk(0, 1, 3, 0, 0, 0, 10, 0, 0, 0), 3, 3, 3, 1, 0);
        tbl[2]  = vec(mk(1, 0, 1, 1, 4, 0, -1, 0, 0, 0), 1, 0, 0, 0, 1);
        tbl[3]  = vec(mk(0, 0, 1, 1, 4, 20, 3, 2, 0, 0), 1, 1, 1, 1, 0);
        tbl[4]  = vec(mk(1, 1, 4, 0, 0, 0, 5, 1, 2, 0), 2, 1, 1, 0, 0);
        tbl[5]  = vec(mk(0, 1, 0, 1, 3, 0, 2, 0, 0, 0), 0, 0, 0, 1, 0);
        tbl[6]  = vec(mk(1, 0, 7, 1, 0, 0, 1, 0, 0, 0), 1, 1, 1, 1, 0);
        tbl[7]  = vec(mk(0, 0, 1, 1, 0, 0, 2, 0, 0, 0), 1, 0, 0, 0, 1);
        tbl[8]  = vec(mk(1, 1, 2, 1, 6, 1, 7, 3, 0, 0), 2, 2, 2, 1, 0);
        tbl[9]  = vec(mk(0, 1, 2, 1, 6, 0, 8, 0, 0, 0), 1, 0, 0, 0, 1);
        tbl[10] = vec(mk(1, 0, 1, 0, 0, 2, 30, 0, 0, 0), 1, 1, 1, 1, 0);
        tbl[11] = vec(mk(0, 0, 1, 0, 0, 0, 3, 0, 0, 1), 1, 0, 0, 0, 1);

        rst_n = 1'b0;
        idle_inputs();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_xfer(tbl[i].x, r);
            e = model(tbl[i].x);
            e.sends = tbl[i].e_sends; e.acks = tbl[i].e_acks; e.done = tbl[i].e_done;
            e.cpl = tbl[i].e_cpl; e.err = tbl[i].e_err;
            check_res($sformatf("vec%0d", i), r, e);
            $display("vec %0d: sends=%0d acks=%0d done=%0d cpl=%0d err=%0d err_cyc=%0d",
                     i, r.sends, r.acks, r.done, r.cpl, r.err, r.err_cyc);
        end

        // Async reset while oAck is held on block 2, then a normal transfer.
        xr = mk(1, 1, 3, 0, 0, 0, 4, 0, 0, 0);
        xr.rst_blk = 2;
        run_xfer(xr, r);
        chk("rst: reached ack of block 2", r.hit, 1);
        chk("rst: done before reset", int'(bus.oBlocks_done), 1);
        chk("rst: oAck before reset", int'(bus.oAck), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-ack reset");
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer(tbl[0].x, r);
        check_res("after reset", r, model(tbl[0].x));
        $display("reset seq: hit=%0d sends=%0d done=%0d cpl=%0d", xr.rst_blk, r.sends, r.done, r.cpl);

        for (int t = 0; t < 40; t++) begin
            int n;
            xr = mk($urandom_range(1), $urandom_range(1), $urandom_range(5), $urandom_range(1),
                    $urandom_range(8), $urandom_range(4), 1, $urandom_range(3), 0,
                    ($urandom_range(7) == 0));
            if (xr.tmo_en) xr.cpl_d = ($urandom_range(3) == 0) ? -1 : $urandom_range(xr.treg + 3, 1);
            else xr.cpl_d = $urandom_range(12, 1);
            n = xr.multi ? xr.blocks : 1;
            if (n > 0 && $urandom_range(3) == 0) xr.abort_blk = $urandom_range(n, 1);
            run_xfer(xr, r);
            e = model(xr);
            check_res($sformatf("rnd%0d", t), r, e);
            $display("rnd %0d: dir=%0d multi=%0d blk=%0d en=%0d treg=%0d d=%0d ext=%0d ab=%0d -> sends=%0d done=%0d cpl=%0d err=%0d",
                     t, xr.dir, xr.multi, xr.blocks, xr.tmo_en, xr.treg, xr.cpl_d, xr.ext,
                     xr.abort_blk, r.sends, r.done, r.cpl, r.err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
